// File: rtl/cs_pkg.sv
// Shared definitions for control_sequencer: state encoding, opcode and ALU codes,
// IR field placement. SEQ_MUL_DIV_EN makes mul/div legal opcodes.
package cs_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_e;

  localparam int OPC_W = 5;
  localparam int ALU_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND = 5'b01001;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;

  localparam logic [ALU_W-1:0] ALU_NOP = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_AND = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_MUL = 5'b01000;
  localparam logic [ALU_W-1:0] ALU_DIV = 5'b01001;

  // LSB of register field idx (0=Ra, 1=Rb, 2=Rc), packed directly below the opcode
  function automatic int field_lsb(input int data_w, input int rw, input int idx);
    return data_w - OPC_W - (idx + 1) * rw;
  endfunction

  function automatic logic op_is_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: ok = 1'b1;
`ifdef SEQ_MUL_DIV_EN
      OP_MUL, OP_DIV:                ok = 1'b1;
`endif
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [ALU_W-1:0] alu_sel(input logic [OPC_W-1:0] op);
    logic [ALU_W-1:0] sel;
    sel = ALU_NOP;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_MUL:  sel = ALU_MUL;
      OP_DIV:  sel = ALU_DIV;
      default: sel = ALU_NOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_sequencer_onehot_decode.sv
// Binary index to one-hot select; all-zero when disabled.
module onehot_decode #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] idx_i,
  input  logic         en_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded-style T-state sequencer driving datapath strobes for fetch and ALU ops.
// Define SEQ_MUL_DIV_EN to add the T5/T6 LO/HI writeback path for mul/div.
module control_sequencer
  import cs_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                Clock,
  input  logic                clr,
  input  logic                run,
  input  logic [DATA_W-1:0]   ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                MDRin,
  output logic                PCin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [ALU_W-1:0]    ALU_select,
  output logic                done,
  output logic                illegal
);

  localparam int RW     = $clog2(NUM_REGS);
  localparam int RA_LSB = field_lsb(DATA_W, RW, 0);
  localparam int RB_LSB = field_lsb(DATA_W, RW, 1);
  localparam int RC_LSB = field_lsb(DATA_W, RW, 2);

  state_e           state_q, state_d;
  logic             wait_q, wait_d;
  logic [OPC_W-1:0] op_q;
  logic [RW-1:0]    ra_q, rb_q, rc_q;
  logic             rin_en, rout_en;
  logic [RW-1:0]    rout_idx;

  always_ff @(posedge Clock) begin
    if (clr) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Fields are captured as T2 ends; ir must present the fetched instruction by then
  always_ff @(posedge Clock) begin
    if (state_q == S_T2) begin
      op_q <= ir[DATA_W-1 -: OPC_W];
      ra_q <= ir[RA_LSB +: RW];
      rb_q <= ir[RB_LSB +: RW];
      rc_q <= ir[RC_LSB +: RW];
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = 1'b0;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    ALU_select = ALU_NOP;
    done       = 1'b0;
    illegal    = 1'b0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_idx   = rb_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        // wait_q marks repeat cycles of a memory stall, so PC is loaded only once
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = ~wait_q;
        if (mem_ready) state_d = S_T2;
        else           wait_d  = 1'b1;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (!op_legal(op_q)) begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end else begin
          rout_en = 1'b1;
          Yin     = 1'b1;
          state_d = S_T4;
        end
      end
      S_T4: begin
        rout_en    = 1'b1;
        rout_idx   = rc_q;
        Zin        = 1'b1;
        ALU_select = alu_sel(op_q);
        state_d    = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
`ifdef SEQ_MUL_DIV_EN
        if (op_is_muldiv(op_q)) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else
`endif
        begin
          rin_en  = 1'b1;
          done    = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
`ifdef SEQ_MUL_DIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        state_d  = run ? S_T0 : S_IDLE;
`else
        state_d  = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  onehot_decode #(.N(NUM_REGS), .W(RW)) u_reg_in_dec (
    .idx_i    (ra_q),
    .en_i     (rin_en),
    .onehot_o (reg_in)
  );

  onehot_decode #(.N(NUM_REGS), .W(RW)) u_reg_out_dec (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction expected cycle plans
// built from the instruction semantics, compared against every DUT output each cycle.
module tb_control_sequencer;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  logic Clock = 1'b0;
  logic clr, run, mem_ready;
  logic [DATA_W-1:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, PCin, IRin;
  logic Yin, Zin, HIin, LOin, IncPC, Read;
  logic [NUM_REGS-1:0] reg_in, reg_out;
  logic [4:0] ALU_select;
  logic done, illegal;

  control_sequencer #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .Clock(Clock), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .reg_in(reg_in), .reg_out(reg_out), .ALU_select(ALU_select),
    .done(done), .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [13:0] s;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        dn;
    logic        ill;
  } obs_t;

  typedef struct packed {
    obs_t e;
    logic mr;
  } step_t;

  localparam logic [13:0] B_PCout   = 14'h2000, B_Zlowout = 14'h1000,
                          B_Zhighout= 14'h0800, B_MDRout  = 14'h0400,
                          B_MARin   = 14'h0200, B_MDRin   = 14'h0100,
                          B_PCin    = 14'h0080, B_IRin    = 14'h0040,
                          B_Yin     = 14'h0020, B_Zin     = 14'h0010,
                          B_HIin    = 14'h0008, B_LOin    = 14'h0004,
                          B_IncPC   = 14'h0002, B_Read    = 14'h0001;

  obs_t obs;
  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, MDRin, PCin, IRin,
                Yin, Zin, HIin, LOin, IncPC, Read,
                reg_in, reg_out, ALU_select, done, illegal};

  int tests = 0;
  int fails = 0;
  step_t plan[$];
  bit plan_legal;
  bit in_t0;

  function automatic obs_t mk(input logic [13:0] s, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [4:0] alu,
                              input logic dn, input logic ill);
    obs_t o;
    o.s = s; o.rin = rin; o.rout = rout; o.alu = alu; o.dn = dn; o.ill = ill;
    return o;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] r);
    logic [15:0] v;
    v = 16'h0001;
    return v << r;
  endfunction

  // Instruction table: legality, mul/div class and ALU code for each opcode
  task automatic ref_op(input logic [4:0] op, output bit legal, output bit md,
                        output logic [4:0] alu);
    legal = 1'b1; md = 1'b0; alu = 5'd0;
    case (op)
      5'b00011: alu = 5'b00001;
      5'b00100: alu = 5'b00010;
      5'b01001: alu = 5'b00100;
      5'b01010: alu = 5'b00101;
      5'b01111: begin md = 1'b1; alu = 5'b01000; end
      5'b10000: begin md = 1'b1; alu = 5'b01001; end
      default:  legal = 1'b0;
    endcase
`ifndef SEQ_MUL_DIV_EN
    if (md) legal = 1'b0;
`endif
  endtask

  task automatic check(input string tag, input obs_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [31:0] irv, input int waits);
    bit legal, md;
    logic [4:0] alu;
    logic [3:0] ra, rb, rc;
    step_t st;
    ra = irv[26:23]; rb = irv[22:19]; rc = irv[18:15];
    ref_op(irv[31:27], legal, md, alu);
    plan_legal = legal;
    plan.delete();
    st.e = mk(B_PCout | B_MARin | B_IncPC | B_Zin, 0, 0, 0, 0, 0);
    st.mr = 1'($urandom_range(0, 1));
    plan.push_back(st);
    for (int w = 0; w <= waits; w++) begin
      st.e = mk(B_Zlowout | B_Read | B_MDRin | ((w == 0) ? B_PCin : 14'h0), 0, 0, 0, 0, 0);
      st.mr = (w == waits);
      plan.push_back(st);
    end
    st.mr = 1'($urandom_range(0, 1));
    st.e = mk(B_MDRout | B_IRin, 0, 0, 0, 0, 0);
    plan.push_back(st);
    if (!legal) begin
      st.e = mk(14'h0, 0, 0, 0, 0, 1);
      plan.push_back(st);
    end else begin
      st.e = mk(B_Yin, 0, oh(rb), 0, 0, 0);
      plan.push_back(st);
      st.e = mk(B_Zin, 0, oh(rc), alu, 0, 0);
      plan.push_back(st);
      if (md) begin
        st.e = mk(B_Zlowout | B_LOin, 0, 0, 0, 0, 0);
        plan.push_back(st);
        st.e = mk(B_Zhighout | B_HIin, 0, 0, 0, 1, 0);
        plan.push_back(st);
      end else begin
        st.e = mk(B_Zlowout, oh(ra), 0, 0, 1, 0);
        plan.push_back(st);
      end
    end
  endtask

  // abort_at: plan index at which clr is pulsed (-1 none, -2 random)
  task automatic run_instr(input string tag, input logic [31:0] irv, input int waits,
                           input bit run_after, input int abort_at);
    int ab;
    ir = irv;
    build(irv, waits);
    ab = (abort_at == -2) ? int'($urandom_range(0, plan.size() - 1)) : abort_at;
    if (!in_t0) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge Clock);
        check({tag, "_idle_hold"}, '0);
        run = 1'b0;
        @(posedge Clock);
      end
      @(negedge Clock);
      check({tag, "_idle"}, '0);
      run = 1'b1;
      @(posedge Clock);
    end
    for (int i = 0; i < plan.size(); i++) begin
      @(negedge Clock);
      check($sformatf("%s_c%0d", tag, i), plan[i].e);
      if (i == ab) begin
        clr = 1'b1; run = 1'b1; mem_ready = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check({tag, "_clr_idle"}, '0);
        @(posedge Clock);
        @(negedge Clock);
        check({tag, "_clr_prio"}, '0);
        clr = 1'b0; run = 1'b0;
        in_t0 = 1'b0;
        return;
      end
      mem_ready = plan[i].mr;
      run = (i == plan.size() - 1) ? run_after : 1'($urandom_range(0, 1));
      @(posedge Clock);
    end
    in_t0 = plan_legal && run_after;
  endtask

  initial begin
    logic [4:0] ops [6];
    logic [4:0] op;
    ops[0] = 5'b00011; ops[1] = 5'b00100; ops[2] = 5'b01001;
    ops[3] = 5'b01010; ops[4] = 5'b01111; ops[5] = 5'b10000;

    clr = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0; in_t0 = 1'b0;
    repeat (3) begin
      @(posedge Clock);
      @(negedge Clock);
      check("reset", '0);
    end
    clr = 1'b0;

    run_instr("and_basic", 32'h4A920000, 0, 1'b0, -1);
    run_instr("t1_stall", {5'b01001, 4'd7, 4'd9, 4'd15, 15'h1234}, 3, 1'b1, -1);
    run_instr("b2b_add", {5'b00011, 4'd0, 4'd15, 4'd1, 15'h0}, 1, 1'b1, -1);
    run_instr("illegal", {5'b11111, 27'h5A5A5A5}, 0, 1'b1, -1);
    run_instr("clr_t4", {5'b00100, 4'd3, 4'd6, 4'd12, 15'h0}, 0, 1'b1, 4);
    run_instr("clr_t1wait", {5'b01010, 4'd1, 4'd2, 4'd3, 15'h0}, 3, 1'b1, 2);
    run_instr("mul", {5'b01111, 4'd8, 4'd10, 4'd11, 15'h7FFF}, 0, 1'b1, -1);
    run_instr("div", {5'b10000, 4'd14, 4'd13, 4'd5, 15'h0}, 2, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else                          op = ops[$urandom_range(0, 5)];
      run_instr($sformatf("rnd%0d", n), {op, 27'($urandom)}, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? -2 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
